fib_gen: RTL and testbench
==========================

# fib_gen

Sequential Fibonacci sequence generator with multi-digit BCD output and a valid/ready output handshake.
- On a start pulse it emits F0, F1, F2, … (0, 1, 1, 2, 3, 5, 8, 13, …) one term per handshake, up to a requested term count or until the BCD width overflows.
- It is the source-side counterpart of the Fibonacci recognizer: it produces the numbers the recognizer accepts.
- It drives display and self-check paths on the board.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits in the output (output width 4*DIGITS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values.
- start  in  1  request a new sequence; sampled only in IDLE.
- n_terms  in  8  number of terms to emit; latched on accepted start.
- out_bcd  out  4*DIGITS  current term, packed BCD, digit 0 in bits [3:0].
- out_valid  out  1  out_bcd holds a valid term.
- out_ready  in  1  consumer accepts the term when out_valid && out_ready at a rising edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sequence ends, for any reason.
- overflow  out  1  sticky; set when a sequence ended because the next term exceeds DIGITS digits; cleared on reset or on the next accepted start.

## Operation
- Registers:
  - a: current term, reset 0.
  - b: next term, reset 1.
  - b_ovf: carry out of b, reset 0.
  - cnt: terms emitted, 8 bits, reset 0.
  - n_lat: latched n_terms, reset 0.
- States are IDLE, EMIT, ADD and FIN.
- IDLE:
  - Outputs are idle: out_valid=0, busy=0.
  - On start: a←0, b←1, b_ovf←0, cnt←0, n_lat←n_terms, overflow←0.
  - Next state is FIN if n_terms==0, else EMIT.
- EMIT: out_valid=1 and out_bcd=a. On handshake, cnt←cnt+1, then the first matching rule applies:
  - cnt+1==n_lat → FIN, overflow unchanged.
  - b_ovf==1 → FIN, overflow←1.
  - Otherwise → ADD.
- EMIT without handshake: hold a and out_valid; out_bcd must stay stable.
- ADD (single cycle): a←b, b←bcd_sum(a,b), b_ovf←carry out of the top digit; next state is EMIT.
- FIN: done=1 for exactly this cycle; next state is IDLE.
- BCD addition:
  - Per digit: s=x+y+cin (5 bits). If s>9, digit=s+6 (low 4 bits) and cout=1; otherwise digit=s and cout=0.
  - Digits ripple from 0 to DIGITS-1 combinationally within the ADD cycle.
- Every emitted digit is in 0..9; out_bcd never shows a wrapped value.
- start outside IDLE is ignored. n_terms changes after latch have no effect.
- With DIGITS=4 the largest emitted term is F20=6765 (21 terms); requests above 21 end with overflow=1.

## Timing
- Reset values: out_bcd=0, out_valid=0, busy=0, done=0, overflow=0, state IDLE.
- Reset is asynchronous at any point, including mid-sequence or mid-handshake. The next sequence starts cleanly from F0.
- Start sampled at edge k → EMIT with out_valid=1, out_bcd=0 during cycle k+1.
- Handshake at edge t → ADD during cycle t+1 → next term valid in cycle t+2. Maximum throughput is one term per 2 cycles.
- Final handshake at edge t → done=1 in cycle t+1 → IDLE in cycle t+2, when a new start is accepted.
- n_terms=0: start at edge k → done=1 in cycle k+1; out_valid is never asserted.
- out_valid, once high, stays high with stable out_bcd until the handshake.

## Structure
- Package fib_pkg:
  - State enum fib_state_t {IDLE, EMIT, ADD, FIN}.
  - Constant BCD_W=4.
  - Default digit count.
- Sub-module bcd_digit_add: one-digit BCD adder, ports x[3:0], y[3:0], cin, s[3:0], cout. fib_gen instantiates DIGITS copies in a generate chain.
- fib_gen holds the FSM, the registers and the output logic.

## Test plan
- n_terms=1, out_ready=1 → one term 0x0000 in the cycle after start, then done pulse; overflow=0.
- n_terms=10, out_ready=1 → out_bcd sequence 0x0000, 0x0001, 0x0001, 0x0002, 0x0003, 0x0005, 0x0008, 0x0013, 0x0021, 0x0034.
  - Valid terms arrive every 2 cycles, then done; busy=1 throughout.
- Backpressure: n_terms=10, out_ready low for 5 cycles while out_bcd=0x0013 → value and out_valid are held for all 5 cycles; no term is skipped or duplicated.
- n_terms=25 → 21 terms, last 0x6765, then done with overflow=1.
  - The next start with n_terms=3 clears overflow and emits 0, 1, 1.
- n_terms=0 → done pulse one cycle after start, out_valid never 1. start during busy is ignored.
- Reset asserted during EMIT of 0x0008 → all outputs go to 0 immediately. After release, start with n_terms=2 emits 0x0000, 0x0001.

Source files
------------

// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_pkg
// Description : Shared types and constants for the Fibonacci BCD generator.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_pkg;

    // Bits per BCD digit
    localparam int BCD_W = 4;

    // Default number of BCD digits in the output term
    localparam int DEFAULT_DIGITS = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ADD  = 2'd2,
        FIN  = 2'd3
    } fib_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_add
// Description : One-digit BCD adder with carry in/out; chained per digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add
    import fib_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             cin,
    output logic [BCD_W-1:0] s,
    output logic             cout
);

    // Raw binary sum fits in 5 bits (max 9+9+1 = 19)
    logic [BCD_W:0]   w_raw;
    logic [BCD_W-1:0] w_adj;
    logic             w_gt9;

    assign w_raw = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
    assign w_gt9 = (w_raw > 5'd9);
    // Adding 6 skips the six unused codes; the carry is taken from w_gt9
    assign w_adj = w_raw[BCD_W-1:0] + 4'd6;

    assign s    = w_gt9 ? w_adj : w_raw[BCD_W-1:0];
    assign cout = w_gt9;

endmodule
`default_nettype wire

// File: rtl/fib_gen.sv
`default_nettype none
// ============================================================================
// Module      : fib_gen
// Description : Fibonacci sequence generator with packed BCD output and a
//               valid/ready handshake. Stops at the requested term count or
//               when the next term would not fit in DIGITS digits.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_gen
    import fib_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              n_terms,
    output logic [BCD_W*DIGITS-1:0] out_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int             c_W   = BCD_W * DIGITS;
    localparam logic [c_W-1:0] c_ONE = c_W'(1);

    fib_state_t     r_state;
    logic [c_W-1:0] r_a;
    logic [c_W-1:0] r_b;
    logic           r_b_ovf;
    logic [7:0]     r_cnt;
    logic [7:0]     r_n_lat;
    logic           r_out_valid;
    logic           r_busy;
    logic           r_done;
    logic           r_overflow;

    logic [c_W-1:0] w_sum;
    logic [DIGITS:0] w_carry;
    logic [7:0]     w_cnt_inc;
    logic           w_handshake;

    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_handshake = r_out_valid && out_ready;

    // Ripple BCD adder computing a+b, digit 0 first
    assign w_carry[0] = 1'b0;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit_add u_digit (
            .x    (r_a[gi*BCD_W +: BCD_W]),
            .y    (r_b[gi*BCD_W +: BCD_W]),
            .cin  (w_carry[gi]),
            .s    (w_sum[gi*BCD_W +: BCD_W]),
            .cout (w_carry[gi+1])
        );
    end

    // Sequencer: term registers, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= c_ONE;
            r_b_ovf     <= 1'b0;
            r_cnt       <= 8'd0;
            r_n_lat     <= 8'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a        <= '0;
                        r_b        <= c_ONE;
                        r_b_ovf    <= 1'b0;
                        r_cnt      <= 8'd0;
                        r_n_lat    <= n_terms;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if (n_terms == 8'd0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= EMIT;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (w_handshake) begin
                        r_cnt       <= w_cnt_inc;
                        r_out_valid <= 1'b0;
                        if (w_cnt_inc == r_n_lat) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else if (r_b_ovf) begin
                            // Next term does not fit: end rather than show a wrapped value
                            r_state    <= FIN;
                            r_done     <= 1'b1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_state <= ADD;
                        end
                    end
                end
                ADD: begin
                    r_a         <= r_b;
                    r_b         <= w_sum;
                    r_b_ovf     <= w_carry[DIGITS];
                    r_state     <= EMIT;
                    r_out_valid <= 1'b1;
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_bcd   = r_a;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fib_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_gen
// Description : Self-checking bench for fib_gen with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_gen;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam longint LIMIT = 10000;   // 10**DIGITS

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   n_terms = 8'd0;
    logic [W-1:0] out_bcd;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         done;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] cap_q[$];

    fib_gen #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_terms   (n_terms),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic longint fib(input int k);
        longint x = 0;
        longint y = 1;
        longint t;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] r = '0;
        longint       t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_valid = 1'b0;
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_ovf   = 1'b0;
    logic [W-1:0] m_bcd   = '0;
    bit           m_gap   = 1'b0;   // one dead cycle between terms
    int           m_k     = 0;      // terms emitted so far
    int           m_n     = 0;      // requested terms

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
            m_bcd = '0; m_gap = 1'b0; m_k = 0; m_n = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_n = int'(n_terms); m_k = 0; m_ovf = 1'b0; m_busy = 1'b1;
                if (m_n == 0) m_done = 1'b1;
                else begin m_valid = 1'b1; m_bcd = to_bcd(fib(0)); end
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_k++;
            if (m_k == m_n) m_done = 1'b1;
            else if (fib(m_k) >= LIMIT) begin m_done = 1'b1; m_ovf = 1'b1; end
            else m_gap = 1'b1;
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_valid = 1'b1;
            m_bcd = to_bcd(fib(m_k));
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_valid) chk("out_bcd", 32'(out_bcd), 32'(m_bcd));
    end

    // Record accepted terms
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) cap_q.push_back(out_bcd);
    end

    // Start a sequence and wait for its done pulse, then the return to idle
    task automatic run_seq(input int n, input bit rnd);
        bit seen = 1'b0;
        cap_q.delete();
        start = 1'b1;
        n_terms = 8'(n);
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin seen = 1'b1; break; end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) begin
                start = ($urandom_range(0, 7) == 0);
                n_terms = 8'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    logic [W-1:0] exp10 [10] = '{16'h0000, 16'h0001, 16'h0001, 16'h0002, 16'h0003,
                                 16'h0005, 16'h0008, 16'h0013, 16'h0021, 16'h0034};

    initial begin
        // Model pins
        chk("model_f7", 32'(to_bcd(fib(7))), 32'h0013);
        chk("model_f20", 32'(to_bcd(fib(20))), 32'h6765);

        repeat (2) @(negedge clk);
        chk("rst_bcd", 32'(out_bcd), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single term: valid with 0 in the cycle after start, then done
        out_ready = 1'b1; start = 1'b1; n_terms = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("n1_valid", 32'(out_valid), 32'h1);
        chk("n1_bcd", 32'(out_bcd), 32'h0);
        @(negedge clk);
        chk("n1_done", 32'(done), 32'h1);
        chk("n1_ovf", 32'(overflow), 32'h0);
        @(negedge clk);

        // Ten terms at full throughput
        run_seq(10, 1'b0);
        chk("n10_count", 32'(cap_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < cap_q.size(); i++) chk("n10_term", 32'(cap_q[i]), 32'(exp10[i]));

        // Backpressure on 13
        cap_q.delete();
        out_ready = 1'b1; start = 1'b1; n_terms = 8'd10;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_bcd == 16'h0013) break;
            @(negedge clk);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_bcd", 32'(out_bcd), 32'h0013);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (done) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("bp_count", 32'(cap_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < cap_q.size(); i++) chk("bp_term", 32'(cap_q[i]), 32'(exp10[i]));

        // Overflow run, then a short run clears overflow
        run_seq(25, 1'b0);
        chk("ovf_count", 32'(cap_q.size()), 32'd21);
        if (cap_q.size() > 0) chk("ovf_last", 32'(cap_q[$]), 32'h6765);
        chk("ovf_flag", 32'(overflow), 32'h1);
        run_seq(3, 1'b0);
        chk("n3_count", 32'(cap_q.size()), 32'd3);
        if (cap_q.size() == 3) begin
            chk("n3_t0", 32'(cap_q[0]), 32'h0);
            chk("n3_t1", 32'(cap_q[1]), 32'h1);
            chk("n3_t2", 32'(cap_q[2]), 32'h1);
        end
        chk("n3_ovf", 32'(overflow), 32'h0);

        // Exactly 21 terms: fits, no overflow
        run_seq(21, 1'b0);
        chk("n21_count", 32'(cap_q.size()), 32'd21);
        chk("n21_ovf", 32'(overflow), 32'h0);

        // Zero terms: done one cycle after start, no valid
        start = 1'b1; n_terms = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("n0_done", 32'(done), 32'h1);
        chk("n0_valid", 32'(out_valid), 32'h0);
        @(negedge clk);

        // Asynchronous reset while 8 is on the output
        cap_q.delete();
        out_ready = 1'b1; start = 1'b1; n_terms = 8'd10;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_bcd == 16'h0008) break;
            @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        chk("arst_bcd", 32'(out_bcd), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_seq(2, 1'b0);
        chk("post_rst_count", 32'(cap_q.size()), 32'd2);
        if (cap_q.size() == 2) begin
            chk("post_rst_t0", 32'(cap_q[0]), 32'h0);
            chk("post_rst_t1", 32'(cap_q[1]), 32'h1);
        end

        // Random lengths, random backpressure, stray starts during busy
        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(0, 30);
            run_seq(n, 1'b1);
            chk("rnd_count", 32'(cap_q.size()), 32'((n < 21) ? n : 21));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
